// File: rtl/cpu_run_controller.sv
// Run/halt/step sequencer gating the accumulator CPU through a per-cycle enable.
// Optional feature: define RESET_TRAP_EN to halt after the CPU retires its RESET opcode.
module cpu_run_controller #(
  parameter int PC_WIDTH        = 4,
  parameter int COUNT_WIDTH     = 16,
  parameter int NUM_BREAKPOINTS = 2
) (
  input  logic                                clock,
  input  logic                                resetN,
  input  logic                                cmdValid,
  output logic                                cmdReady,
  input  logic [1:0]                          cmdOp,
  input  logic [COUNT_WIDTH-1:0]              cmdCount,
  input  logic [PC_WIDTH-1:0]                 pc,
  input  logic                                isReset,
  input  logic [NUM_BREAKPOINTS-1:0]          bpEnable,
  input  logic [NUM_BREAKPOINTS*PC_WIDTH-1:0] bpAddr,
  output logic                                cpuEnable,
  output logic [1:0]                          state,
  output logic [2:0]                          haltCause,
  output logic [COUNT_WIDTH-1:0]              retiredCount,
  output logic                                cmdError
);

  typedef enum logic [1:0] {
    ST_HALTED   = 2'd0,
    ST_RUNNING  = 2'd1,
    ST_STEPPING = 2'd2
  } run_state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE       = 3'd0,
    CAUSE_HOST       = 3'd1,
    CAUSE_BREAKPOINT = 3'd2,
    CAUSE_COUNT      = 3'd3,
    CAUSE_RESET_TRAP = 3'd4
  } halt_cause_t;

  localparam logic [1:0] OP_HALT  = 2'd0;
  localparam logic [1:0] OP_RUN   = 2'd1;
  localparam logic [1:0] OP_STEP  = 2'd2;
  localparam logic [1:0] OP_RUN_N = 2'd3;

  localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  run_state_t              state_q, state_d;
  halt_cause_t             cause_q, cause_d;
  logic [COUNT_WIDTH-1:0]  retired_q, retired_d;
  logic [COUNT_WIDTH-1:0]  remaining_q, remaining_d;
  logic                    bounded_q, bounded_d;
  logic                    skip_bp_q, skip_bp_d;
  logic                    cmd_error_q, cmd_error_d;
  logic                    accept;
  logic                    halt_req;
  logic                    bp_hit;
  logic                    cpu_en;

  // Handshake: a command transfers on any cycle with cmdValid high; cmdReady is
  // tied high so the host never stalls, and commands that do not apply are dropped.
  assign cmdReady = 1'b1;
  assign accept   = cmdValid && cmdReady;
  assign halt_req = accept && (cmdOp == OP_HALT);

  always_comb begin
    bp_hit = 1'b0;
    for (int i = 0; i < NUM_BREAKPOINTS; i++) begin
      if (bpEnable[i] && (pc == bpAddr[i*PC_WIDTH +: PC_WIDTH])) begin
        bp_hit = 1'b1;
      end
    end
  end

`ifndef RESET_TRAP_EN
  logic unused_inputs;
  assign unused_inputs = isReset;
`endif

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    retired_d   = retired_q;
    remaining_d = remaining_q;
    bounded_d   = bounded_q;
    skip_bp_d   = skip_bp_q;
    cpu_en      = 1'b0;
    cmd_error_d = accept && (cmdOp != OP_HALT) && (state_q != ST_HALTED);

    case (state_q)
      ST_HALTED: begin
        if (accept) begin
          case (cmdOp)
            OP_HALT: cause_d = CAUSE_HOST;
            OP_RUN, OP_RUN_N: begin
              state_d   = ST_RUNNING;
              bounded_d = (cmdOp == OP_RUN_N);
              skip_bp_d = 1'b1;
              retired_d = '0;
              cause_d   = CAUSE_NONE;
              if (cmdOp == OP_RUN_N) begin
                remaining_d = cmdCount;
              end
            end
            OP_STEP: begin
              state_d   = ST_STEPPING;
              retired_d = '0;
              cause_d   = CAUSE_NONE;
            end
            default: ;
          endcase
        end
      end

      ST_RUNNING: begin
        // Stop conditions are checked in priority order before enabling the core.
        if (halt_req) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_HOST;
        end else if (bounded_q && (remaining_q == '0)) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_COUNT;
        end else if (bp_hit && !skip_bp_q) begin
          state_d = ST_HALTED;
          cause_d = CAUSE_BREAKPOINT;
        end else begin
          cpu_en = 1'b1;
`ifdef RESET_TRAP_EN
          if (isReset) begin
            state_d = ST_HALTED;
            cause_d = CAUSE_RESET_TRAP;
          end
`endif
        end
      end

      ST_STEPPING: begin
        cpu_en  = 1'b1;
        state_d = ST_HALTED;
        cause_d = halt_req ? CAUSE_HOST : CAUSE_COUNT;
      end

      default: state_d = ST_HALTED;
    endcase

    if (cpu_en) begin
      if (retired_q != '1) begin
        retired_d = retired_q + COUNT_ONE;
      end
      if (bounded_q && (remaining_q != '0)) begin
        remaining_d = remaining_q - COUNT_ONE;
      end
      skip_bp_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= ST_HALTED;
      cause_q     <= CAUSE_NONE;
      retired_q   <= '0;
      remaining_q <= '0;
      bounded_q   <= 1'b0;
      skip_bp_q   <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      retired_q   <= retired_d;
      remaining_q <= remaining_d;
      bounded_q   <= bounded_d;
      skip_bp_q   <= skip_bp_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  // Enable must fall with reset even before the next clock edge.
  assign cpuEnable    = cpu_en && resetN;
  assign state        = state_q;
  assign haltCause    = cause_q;
  assign retiredCount = retired_q;
  assign cmdError     = cmd_error_q;

endmodule
